// File: rtl/qsfp_mon_pkg.sv
// Shared definitions for the QSFP/Aurora status monitor: debounce FSM states,
// default sizing constants and the bit positions of each status signal in the
// AXI status register word.
package qsfp_mon_pkg;

  // Debounce FSM states
  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  // Default sizing
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1024;
  localparam int unsigned DEFAULT_CNT_WIDTH       = 16;
  localparam int unsigned STATUS_LANE_BITS        = 4;

  // Bit positions in the status register word
  localparam int unsigned SSW_CHANNEL_UP      = 0;
  localparam int unsigned SSW_GT_PLL_LOCK     = 1;
  localparam int unsigned SSW_LANE_UP_LSB     = 2;
  localparam int unsigned SSW_LANE_UP_MSB     = 5;
  localparam int unsigned SSW_HARD_ERR        = 6;
  localparam int unsigned SSW_MMCM_NOT_LOCKED = 7;
  localparam int unsigned SSW_SOFT_ERR        = 8;
  localparam int unsigned SSW_C2C_LINK_STATUS = 16;
  localparam int unsigned SSW_C2C_LINK_ERROR  = 17;

endpackage

// File: rtl/status_debounce.sv
// Single-bit 2-flop synchronizer followed by a STABLE/PENDING debounce FSM.
// The debounced level is registered once more before leaving the block, so an
// input change that stays put reaches level_o DEBOUNCE_CYCLES+2 edges after
// it is first sampled.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   raw_i        level input, asynchronous to clk
//   level_o      debounced, registered level
module status_debounce
  import qsfp_mon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

  logic      sync1_q, sync2_q;
  db_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic      level_q, level_d;
  logic      out_q;

  // Synchronizer, FSM state and output register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      out_q   <= level_q;
    end
  end

  // Next-state: qualify a change only after it holds long enough
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    unique case (state_q)
      DB_STABLE: begin
        if (sync2_q != level_q) begin
          if (SINGLE_CYCLE) begin
            level_d = ~level_q;
          end else begin
            state_d = DB_PENDING;
            cnt_d   = CW'(1);
          end
        end
      end
      DB_PENDING: begin
        if (sync2_q == level_q) begin
          // glitch rejected
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_d = ~level_q;
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = out_q;

endmodule

// File: rtl/qsfp_status_monitor.sv
// Conditions raw QSFP/Aurora link status for the AXI status register block:
// synchronizes every raw bit, debounces level status, turns error pulses into
// sticky flags and (optionally) saturating event counters.
// Build option: define QSFP_MON_COUNTERS_EN to build the three event counters
// and the link-drop edge detector; otherwise the counts are tied to 0.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   raw_*                   asynchronous level / error inputs
//   clear                   single-cycle pulse clearing flags and counters
//   ss_* (levels)           debounced levels
//   ss_* (errors)           sticky error flags
//   *_count                 saturating event counts
module qsfp_status_monitor
  import qsfp_mon_pkg::*;
#(
  parameter int unsigned LANE_COUNT      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  raw_channel_up,
  input  logic                  raw_gt_pll_lock,
  input  logic                  raw_mmcm_not_locked_out,
  input  logic                  raw_c2c_link_status,
  input  logic [LANE_COUNT-1:0] raw_lane_up,
  input  logic                  raw_hard_err,
  input  logic                  raw_soft_err,
  input  logic                  raw_c2c_link_error,
  input  logic                  clear,
  output logic                  ss_channel_up,
  output logic                  ss_gt_pll_lock,
  output logic                  ss_mcmm_not_locked_out,
  output logic                  ss_c2c_link_status,
  output logic [LANE_COUNT-1:0] ss_lane_up,
  output logic                  ss_hard_err,
  output logic                  ss_soft_err,
  output logic                  ss_c2c_link_error,
  output logic [CNT_WIDTH-1:0]  hard_err_count,
  output logic [CNT_WIDTH-1:0]  soft_err_count,
  output logic [CNT_WIDTH-1:0]  link_drop_count
);

  localparam int unsigned LEVEL_W = 4 + LANE_COUNT;
  localparam int unsigned ERR_W   = 3;

  // ---------------- level status: one debouncer per bit ----------------
  logic [LEVEL_W-1:0] lvl_raw;
  logic [LEVEL_W-1:0] lvl_ss;

  assign lvl_raw = {raw_lane_up, raw_c2c_link_status, raw_mmcm_not_locked_out,
                    raw_gt_pll_lock, raw_channel_up};

  for (genvar g = 0; g < LEVEL_W; g++) begin : g_db
    status_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .resetn (resetn),
      .raw_i  (lvl_raw[g]),
      .level_o(lvl_ss[g])
    );
  end

  assign ss_channel_up          = lvl_ss[0];
  assign ss_gt_pll_lock         = lvl_ss[1];
  assign ss_mcmm_not_locked_out = lvl_ss[2];
  assign ss_c2c_link_status     = lvl_ss[3];
  assign ss_lane_up             = lvl_ss[4 +: LANE_COUNT];

  // ---------------- error pulses: sync, edge detect, sticky ----------------
  // bit 0 hard_err, bit 1 soft_err, bit 2 c2c_link_error
  logic [ERR_W-1:0] err_raw;
  logic [ERR_W-1:0] err_s1_q, err_s2_q, err_prev_q;
  logic [ERR_W-1:0] err_flag_q, err_flag_d;
  logic [ERR_W-1:0] err_evt_c;

  assign err_raw = {raw_c2c_link_error, raw_soft_err, raw_hard_err};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_s1_q   <= '0;
      err_s2_q   <= '0;
      err_prev_q <= '0;
      err_flag_q <= '0;
    end else begin
      err_s1_q   <= err_raw;
      err_s2_q   <= err_s1_q;
      err_prev_q <= err_s2_q;
      err_flag_q <= err_flag_d;
    end
  end

  // An event in the clear cycle still sets the flag
  always_comb begin
    err_evt_c  = err_s2_q & ~err_prev_q;
    err_flag_d = err_evt_c | (err_flag_q & {ERR_W{~clear}});
  end

  assign ss_hard_err       = err_flag_q[0];
  assign ss_soft_err       = err_flag_q[1];
  assign ss_c2c_link_error = err_flag_q[2];

`ifdef QSFP_MON_COUNTERS_EN
  // ---------------- saturating event counters ----------------
  // index 0 hard_err, 1 soft_err, 2 link drop
  logic                 ch_up_prev_q;
  logic                 drop_evt_c;
  logic [2:0]           cnt_evt_c;
  logic [CNT_WIDTH-1:0] cnt_q [3];
  logic [CNT_WIDTH-1:0] cnt_d [3];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ch_up_prev_q <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      ch_up_prev_q <= ss_channel_up;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Clear loses to a same-cycle event; counts hold at all-ones
  always_comb begin
    drop_evt_c = ch_up_prev_q & ~ss_channel_up;
    cnt_evt_c  = {drop_evt_c, err_evt_c[1], err_evt_c[0]};
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = cnt_evt_c[i] ? CNT_WIDTH'(1) : '0;
      end else if (cnt_evt_c[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign hard_err_count  = cnt_q[0];
  assign soft_err_count  = cnt_q[1];
  assign link_drop_count = cnt_q[2];
`else
  assign hard_err_count  = '0;
  assign soft_err_count  = '0;
  assign link_drop_count = '0;
`endif

endmodule

// File: tb/tb_qsfp_status_monitor.sv
// Directed bench for qsfp_status_monitor with DEBOUNCE_CYCLES=8, CNT_WIDTH=4.
// Counter expectations follow the QSFP_MON_COUNTERS_EN build option.
module tb_qsfp_status_monitor;

  localparam int unsigned LANES = 4;
  localparam int unsigned DEB   = 8;
  localparam int unsigned CW    = 4;
`ifdef QSFP_MON_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             raw_channel_up, raw_gt_pll_lock, raw_mmcm_not_locked_out;
  logic             raw_c2c_link_status;
  logic [LANES-1:0] raw_lane_up;
  logic             raw_hard_err, raw_soft_err, raw_c2c_link_error;
  logic             clear;
  logic             ss_channel_up, ss_gt_pll_lock, ss_mcmm_not_locked_out;
  logic             ss_c2c_link_status;
  logic [LANES-1:0] ss_lane_up;
  logic             ss_hard_err, ss_soft_err, ss_c2c_link_error;
  logic [CW-1:0]    hard_err_count, soft_err_count, link_drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  qsfp_status_monitor #(
    .LANE_COUNT(LANES), .DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .raw_channel_up(raw_channel_up), .raw_gt_pll_lock(raw_gt_pll_lock),
    .raw_mmcm_not_locked_out(raw_mmcm_not_locked_out),
    .raw_c2c_link_status(raw_c2c_link_status), .raw_lane_up(raw_lane_up),
    .raw_hard_err(raw_hard_err), .raw_soft_err(raw_soft_err),
    .raw_c2c_link_error(raw_c2c_link_error), .clear(clear),
    .ss_channel_up(ss_channel_up), .ss_gt_pll_lock(ss_gt_pll_lock),
    .ss_mcmm_not_locked_out(ss_mcmm_not_locked_out),
    .ss_c2c_link_status(ss_c2c_link_status), .ss_lane_up(ss_lane_up),
    .ss_hard_err(ss_hard_err), .ss_soft_err(ss_soft_err),
    .ss_c2c_link_error(ss_c2c_link_error),
    .hard_err_count(hard_err_count), .soft_err_count(soft_err_count),
    .link_drop_count(link_drop_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 ns after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [19:0] all_out;
    resetn = 1'b0;
    raw_channel_up = 0; raw_gt_pll_lock = 0; raw_mmcm_not_locked_out = 0;
    raw_c2c_link_status = 0; raw_lane_up = '0; raw_hard_err = 0;
    raw_soft_err = 0; raw_c2c_link_error = 0; clear = 0;
    tick(3);
    all_out = {ss_channel_up, ss_gt_pll_lock, ss_mcmm_not_locked_out,
               ss_c2c_link_status, ss_lane_up, ss_hard_err, ss_soft_err,
               ss_c2c_link_error, hard_err_count, soft_err_count[0]};
    n_cmp++;
    if (all_out !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    resetn = 1'b1;
    tick(2);
  endtask

  task automatic test_channel_up;
    raw_channel_up = 1'b1;
    tick(DEB + 2);
    n_cmp++;
    if (ss_channel_up !== 1'b0) begin
      n_bad++;
      $display("FAIL chup_early: got %b expected 0", ss_channel_up);
    end
    tick(1);
    n_cmp++;
    if (ss_channel_up !== 1'b1) begin
      n_bad++;
      $display("FAIL chup_rise: got %b expected 1", ss_channel_up);
    end
    n_cmp++;
    if (link_drop_count !== CW'(0)) begin
      n_bad++;
      $display("FAIL chup_drop_cnt: got %0d expected 0", link_drop_count);
    end
  endtask

  task automatic test_lane_glitch;
    raw_lane_up[2] = 1'b1;
    tick(5);
    raw_lane_up[2] = 1'b0;
    tick(20);
    n_cmp++;
    if (ss_lane_up !== 4'b0000) begin
      n_bad++;
      $display("FAIL lane_glitch: got %b expected 0000", ss_lane_up);
    end
    // a fresh change must take the full qualification time again
    raw_lane_up[2] = 1'b1;
    tick(DEB + 2);
    n_cmp++;
    if (ss_lane_up !== 4'b0000) begin
      n_bad++;
      $display("FAIL lane_requal_early: got %b expected 0000", ss_lane_up);
    end
    tick(1);
    n_cmp++;
    if (ss_lane_up !== 4'b0100) begin
      n_bad++;
      $display("FAIL lane_requal: got %b expected 0100", ss_lane_up);
    end
  endtask

  task automatic test_soft_err;
    raw_soft_err = 1'b1;
    tick(2);
    n_cmp++;
    if (ss_soft_err !== 1'b0) begin
      n_bad++;
      $display("FAIL soft_latency_early: got %b expected 0", ss_soft_err);
    end
    raw_soft_err = 1'b0;
    tick(1);
    n_cmp++;
    if (ss_soft_err !== 1'b1) begin
      n_bad++;
      $display("FAIL soft_latency: got %b expected 1", ss_soft_err);
    end
    tick(3);
    repeat (2) begin
      raw_soft_err = 1'b1; tick(2);
      raw_soft_err = 1'b0; tick(4);
    end
    n_cmp++;
    if (soft_err_count !== (CNT_EN ? CW'(3) : CW'(0))) begin
      n_bad++;
      $display("FAIL soft_count: got %0d expected %0d", soft_err_count, CNT_EN ? 3 : 0);
    end
    n_cmp++;
    if (ss_hard_err !== 1'b0) begin
      n_bad++;
      $display("FAIL soft_cross_hard: got %b expected 0", ss_hard_err);
    end
    clear = 1'b1; tick(1); clear = 1'b0;
    n_cmp++;
    if ({ss_soft_err, soft_err_count} !== 5'b0) begin
      n_bad++;
      $display("FAIL soft_clear: got flag %b count %0d expected 0 0", ss_soft_err, soft_err_count);
    end
    n_cmp++;
    if (ss_channel_up !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_keeps_level: got %b expected 1", ss_channel_up);
    end
  endtask

  task automatic test_hard_saturate;
    repeat (17) begin
      raw_hard_err = 1'b1; tick(2);
      raw_hard_err = 1'b0; tick(2);
    end
    tick(2);
    n_cmp++;
    if (hard_err_count !== (CNT_EN ? CW'(15) : CW'(0))) begin
      n_bad++;
      $display("FAIL hard_saturate: got %0d expected %0d", hard_err_count, CNT_EN ? 15 : 0);
    end
    n_cmp++;
    if (ss_hard_err !== 1'b1) begin
      n_bad++;
      $display("FAIL hard_flag: got %b expected 1", ss_hard_err);
    end
    clear = 1'b1; tick(1); clear = 1'b0;
    n_cmp++;
    if ({ss_hard_err, hard_err_count} !== 5'b0) begin
      n_bad++;
      $display("FAIL hard_clear: got flag %b count %0d expected 0 0", ss_hard_err, hard_err_count);
    end
    // clear lands on the same edge as the event update
    raw_hard_err = 1'b1; tick(2);
    clear = 1'b1; raw_hard_err = 1'b0; tick(1); clear = 1'b0;
    n_cmp++;
    if ({ss_hard_err, hard_err_count} !== {1'b1, (CNT_EN ? CW'(1) : CW'(0))}) begin
      n_bad++;
      $display("FAIL clear_vs_evt: got flag %b count %0d expected 1 %0d", ss_hard_err, hard_err_count, CNT_EN ? 1 : 0);
    end
    tick(3);
    n_cmp++;
    if (hard_err_count !== (CNT_EN ? CW'(1) : CW'(0))) begin
      n_bad++;
      $display("FAIL clear_vs_evt_hold: got %0d expected %0d", hard_err_count, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_other_bits;
    raw_gt_pll_lock = 1'b1; raw_mmcm_not_locked_out = 1'b1;
    raw_c2c_link_status = 1'b1; raw_c2c_link_error = 1'b1;
    tick(2);
    n_cmp++;
    if (ss_c2c_link_error !== 1'b0) begin
      n_bad++;
      $display("FAIL c2c_err_early: got %b expected 0", ss_c2c_link_error);
    end
    raw_c2c_link_error = 1'b0;
    tick(1);
    n_cmp++;
    if (ss_c2c_link_error !== 1'b1) begin
      n_bad++;
      $display("FAIL c2c_err: got %b expected 1", ss_c2c_link_error);
    end
    tick(DEB - 1);
    n_cmp++;
    if ({ss_gt_pll_lock, ss_mcmm_not_locked_out, ss_c2c_link_status} !== 3'b000) begin
      n_bad++;
      $display("FAIL levels_early: got %b expected 000", {ss_gt_pll_lock, ss_mcmm_not_locked_out, ss_c2c_link_status});
    end
    tick(1);
    n_cmp++;
    if ({ss_gt_pll_lock, ss_mcmm_not_locked_out, ss_c2c_link_status} !== 3'b111) begin
      n_bad++;
      $display("FAIL levels_rise: got %b expected 111", {ss_gt_pll_lock, ss_mcmm_not_locked_out, ss_c2c_link_status});
    end
    n_cmp++;
    if ({ss_soft_err, soft_err_count} !== 5'b0) begin
      n_bad++;
      $display("FAIL c2c_cross_soft: got flag %b count %0d expected 0 0", ss_soft_err, soft_err_count);
    end
  endtask

  task automatic test_link_drop;
    for (int i = 0; i < 2; i++) begin
      raw_channel_up = 1'b0;
      tick(DEB + 2);
      n_cmp++;
      if (ss_channel_up !== 1'b1) begin
        n_bad++;
        $display("FAIL drop_early_%0d: got %b expected 1", i, ss_channel_up);
      end
      tick(1);
      n_cmp++;
      if (ss_channel_up !== 1'b0) begin
        n_bad++;
        $display("FAIL drop_fall_%0d: got %b expected 0", i, ss_channel_up);
      end
      tick(2);
      n_cmp++;
      if (link_drop_count !== (CNT_EN ? CW'(i + 1) : CW'(0))) begin
        n_bad++;
        $display("FAIL drop_count_%0d: got %0d expected %0d", i, link_drop_count, CNT_EN ? i + 1 : 0);
      end
      raw_channel_up = 1'b1;
      tick(DEB + 4);
    end
    n_cmp++;
    if ({ss_channel_up, link_drop_count} !== {1'b1, (CNT_EN ? CW'(2) : CW'(0))}) begin
      n_bad++;
      $display("FAIL drop_final: got up %b count %0d expected 1 %0d", ss_channel_up, link_drop_count, CNT_EN ? 2 : 0);
    end
  endtask

  task automatic test_reset_midop;
    logic [22:0] all_out;
    raw_lane_up[0] = 1'b1;
    tick(4);  // lane 0 debouncer now pending
    resetn = 1'b0;
    #1;
    all_out = {ss_channel_up, ss_gt_pll_lock, ss_mcmm_not_locked_out,
               ss_c2c_link_status, ss_lane_up, ss_hard_err, ss_soft_err,
               ss_c2c_link_error, hard_err_count, soft_err_count, link_drop_count};
    n_cmp++;
    if (all_out !== 23'h0) begin
      n_bad++;
      $display("FAIL reset_midop: got %h expected 0", all_out);
    end
    tick(2);
    resetn = 1'b1;
    tick(DEB + 2);
    n_cmp++;
    if ({ss_channel_up, ss_lane_up} !== 5'b0) begin
      n_bad++;
      $display("FAIL requal_early: got %b expected 00000", {ss_channel_up, ss_lane_up});
    end
    tick(1);
    n_cmp++;
    if ({ss_channel_up, ss_gt_pll_lock, ss_mcmm_not_locked_out, ss_c2c_link_status, ss_lane_up}
        !== 8'b1111_0101) begin
      n_bad++;
      $display("FAIL requal: got %b expected 11110101",
               {ss_channel_up, ss_gt_pll_lock, ss_mcmm_not_locked_out, ss_c2c_link_status, ss_lane_up});
    end
    n_cmp++;
    if ({ss_hard_err, ss_c2c_link_error, hard_err_count} !== 6'b0) begin
      n_bad++;
      $display("FAIL requal_flags: got %b expected 0", {ss_hard_err, ss_c2c_link_error, hard_err_count});
    end
  endtask

  initial begin
    test_reset();
    test_channel_up();
    test_lane_glitch();
    test_soft_err();
    test_hard_saturate();
    test_other_bits();
    test_link_drop();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
